operand_entry: RTL and testbench

Front-end capture stage for the ALU datapath. Synchronizes the 16 operand switches and three active-low push buttons onto `clk_i`, debounces the buttons and turns each press into a single-cycle load. Each load registers the operands A, B and the control nibble C, which the ALU and the bin2dec/LCD display path consume. Replaces direct button-edge clocking of operand registers with a fully synchronous single-clock design.

---
 rtl/operand_entry_if.sv | 24 ++
 rtl/operand_entry.sv | 114 +++++++++++
 tb/tb_operand_entry.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_entry_if.sv
// Operand entry bus: raw switch/key inputs toward the capture stage and the
// registered operands, load pulses and status flowing back out.
interface operand_entry_if;
  logic [15:0] data_i;
  logic        key_a_n;
  logic        key_b_n;
  logic        key_c_n;
  logic [15:0] A_o;
  logic [15:0] B_o;
  logic [3:0]  C_o;
  logic [2:0]  load_o;
  logic        update_o;
  logic        valid_o;

  modport master (
    output data_i, key_a_n, key_b_n, key_c_n,
    input  A_o, B_o, C_o, load_o, update_o, valid_o
  );

  modport slave (
    input  data_i, key_a_n, key_b_n, key_c_n,
    output A_o, B_o, C_o, load_o, update_o, valid_o
  );
endinterface

// File: rtl/operand_entry.sv
// Operand capture stage: syncs switches/keys, debounces the three load keys and
// registers A, B, C on each press. Debounce counters exist only with OPERAND_ENTRY_DEBOUNCE_EN.
module operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input logic            clk_i,
  input logic            rstn,
  operand_entry_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $fatal(1, "DEBOUNCE_CYCLES must be at least 1");
  end

  logic [15:0] data_s1_q, data_s2_q;
  logic [2:0]  key_s1_q, key_s2_q;
  logic [2:0]  stable, stable_q, press;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [3:0]  c_q, c_d;
  logic [2:0]  load_q, load_d;
  logic [2:0]  seen_q, seen_d;

  // Keys idle high, so their synchronizers reset to 1 to avoid a false press.
  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      data_s1_q <= '0;
      data_s2_q <= '0;
      key_s1_q  <= '1;
      key_s2_q  <= '1;
    end else begin
      data_s1_q <= bus.data_i;
      data_s2_q <= data_s1_q;
      key_s1_q  <= {bus.key_c_n, bus.key_b_n, bus.key_a_n};
      key_s2_q  <= key_s1_q;
    end
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]         stable_db_q, stable_db_d;

  // Any sample matching the accepted level restarts the run, so glitches never flip it.
  always_comb begin
    cnt_d       = cnt_q;
    stable_db_d = stable_db_q;
    for (int i = 0; i < 3; i++) begin
      if (key_s2_q[i] == stable_db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_db_d[i] = key_s2_q[i];
        cnt_d[i]       = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      cnt_q       <= '0;
      stable_db_q <= '1;
    end else begin
      cnt_q       <= cnt_d;
      stable_db_q <= stable_db_d;
    end
  end

  assign stable = stable_db_q;
`else
  assign stable = key_s2_q;
`endif

  assign press = stable_q & ~stable;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    c_d    = c_q;
    load_d = press;
    seen_d = seen_q | press;
    if (press[0]) a_d = data_s2_q;
    if (press[1]) b_d = data_s2_q;
    if (press[2]) c_d = data_s2_q[3:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      stable_q <= '1;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      load_q   <= '0;
      seen_q   <= '0;
    end else begin
      stable_q <= stable;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      load_q   <= load_d;
      seen_q   <= seen_d;
    end
  end

  assign bus.A_o      = a_q;
  assign bus.B_o      = b_q;
  assign bus.C_o      = c_q;
  assign bus.load_o   = load_q;
  assign bus.update_o = |load_q;
  assign bus.valid_o  = &seen_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed press scenarios plus randomized bouncy keys
// checked against a sample-history reference model.
module tb_operand_entry;
  localparam int D = 4;
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = D + 3;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  operand_entry_if bus();
  operand_entry #(.DEBOUNCE_CYCLES(D)) dut (.clk_i(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference model: history of raw samples, one entry per clock edge.
  logic [2:0]  m_kh[$];
  logic [15:0] m_dh[$];
  logic [2:0]  m_stable = 3'b111;
  logic [2:0]  m_fell = 3'b000;
  logic [2:0]  m_load = 3'b000;
  logic [2:0]  m_flags = 3'b000;
  int          m_run[3] = '{0, 0, 0};
  logic [15:0] m_a = 16'h0, m_b = 16'h0;
  logic [3:0]  m_c = 4'h0;

  function automatic logic [2:0] key_ago(int back);
    int idx = m_kh.size() - 1 - back;
    return (idx < 0) ? 3'b111 : m_kh[idx];
  endfunction

  function automatic logic [15:0] data_ago(int back);
    int idx = m_dh.size() - 1 - back;
    return (idx < 0) ? 16'h0 : m_dh[idx];
  endfunction

  function automatic void model_step();
    logic [2:0]  sk;
    logic [15:0] sd;
    if (!rstn) begin
      m_kh.delete();
      m_dh.delete();
      m_stable = 3'b111;
      m_fell   = 3'b000;
      m_load   = 3'b000;
      m_flags  = 3'b000;
      m_run    = '{0, 0, 0};
      m_a = 16'h0; m_b = 16'h0; m_c = 4'h0;
    end else begin
      m_kh.push_back({bus.key_c_n, bus.key_b_n, bus.key_a_n});
      m_dh.push_back(bus.data_i);
      if (m_kh.size() > 4) begin
        void'(m_kh.pop_front());
        void'(m_dh.pop_front());
      end
      sk = key_ago(2);
      sd = data_ago(2);
      if (DEB) begin
        // Key is accepted after D consecutive synced samples differing from the accepted level.
        m_load = m_fell;
        for (int i = 0; i < 3; i++) begin
          m_fell[i] = 1'b0;
          if (sk[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == D) begin
              m_stable[i] = sk[i];
              m_run[i]    = 0;
              m_fell[i]   = ~sk[i];
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end else begin
        m_load = ~sk & key_ago(3);
      end
      if (m_load[0]) m_a = sd;
      if (m_load[1]) m_b = sd;
      if (m_load[2]) m_c = sd[3:0];
      m_flags |= m_load;
    end
  endfunction

  always @(posedge clk) model_step();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      checks++;
      if (bus.load_o !== 3'b000 || bus.update_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_pulse cycle %0d: load=%b update=%b, required 000/0", n, bus.load_o, bus.update_o);
      end
    end
    checks++;
    if ({bus.A_o, bus.B_o, bus.C_o, bus.valid_o} !== 37'h0) begin
      failures++;
      $display("FAIL reset_outputs: A=%h B=%h C=%h valid=%b, required all zero", bus.A_o, bus.B_o, bus.C_o, bus.valid_o);
    end
  endtask

  task automatic test_single_a();
    int pulses = 0, at = -1;
    logic [2:0] seen = 3'b000;
    bus.data_i  = 16'h1234;
    bus.key_a_n = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == 10) bus.key_a_n = 1'b1;
      if (bus.load_o !== 3'b000) begin
        pulses++;
        seen |= bus.load_o;
        if (at < 0) at = n;
      end
    end
    checks++;
    if (pulses != 1 || at != LAT || seen !== 3'b001) begin
      failures++;
      $display("FAIL single_a_pulse: count=%0d at=%0d load=%b, required 1 at %0d load=001", pulses, at, seen, LAT);
    end
    checks++;
    if (bus.A_o !== 16'h1234 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL single_a_value: A=%h valid=%b, required 1234/0", bus.A_o, bus.valid_o);
    end
  endtask

  task automatic test_bounce_b();
    int pulses = 0, last = -1, upd = 0;
    logic [2:0] seen = 3'b000;
    bus.data_i = 16'hFFFE;
    for (int n = 1; n <= 35; n++) begin
      bus.key_b_n = (n <= 2 || (n >= 4 && n <= 5) || (n >= 7 && n <= 16)) ? 1'b0 : 1'b1;
      step();
      if (bus.update_o === 1'b1) upd++;
      if (bus.load_o !== 3'b000) begin
        pulses++;
        seen |= bus.load_o;
        last = n;
      end
    end
    bus.key_b_n = 1'b1;
    checks++;
    if (pulses != (DEB ? 1 : 3) || upd != pulses || seen !== 3'b010) begin
      failures++;
      $display("FAIL bounce_b_count: loads=%0d updates=%0d load=%b, required %0d/%0d/010", pulses, upd, seen, DEB ? 1 : 3, DEB ? 1 : 3);
    end
    checks++;
    if (last != 7 + LAT - 1) begin
      failures++;
      $display("FAIL bounce_b_timing: last pulse at %0d, required %0d", last, 7 + LAT - 1);
    end
    checks++;
    if (bus.B_o !== 16'hFFFE) begin
      failures++;
      $display("FAIL bounce_b_value: B=%h, required fffe", bus.B_o);
    end
  endtask

  task automatic test_simult_ac();
    int pulses = 0, upd = 0, at = -1;
    logic [2:0] seen = 3'b000;
    bus.data_i  = 16'h000B;
    bus.key_a_n = 1'b0;
    bus.key_c_n = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (n == 10) begin
        bus.key_a_n = 1'b1;
        bus.key_c_n = 1'b1;
      end
      if (bus.update_o === 1'b1) upd++;
      if (bus.load_o !== 3'b000) begin
        pulses++;
        seen |= bus.load_o;
        if (at < 0) at = n;
      end
    end
    checks++;
    if (pulses != 1 || upd != 1 || seen !== 3'b101 || at != LAT) begin
      failures++;
      $display("FAIL simult_ac_pulse: loads=%0d updates=%0d load=%b at=%0d, required 1/1/101 at %0d", pulses, upd, seen, at, LAT);
    end
    checks++;
    if (bus.A_o !== 16'h000B || bus.C_o !== 4'hB || bus.valid_o !== 1'b1) begin
      failures++;
      $display("FAIL simult_ac_value: A=%h C=%h valid=%b, required 000b/b/1", bus.A_o, bus.C_o, bus.valid_o);
    end
  endtask

  task automatic test_reset_mid();
    int early = 0, pulses = 0, at = -1;
    bus.data_i  = 16'h5A5A;
    bus.key_a_n = 1'b0;
    repeat (2) begin
      step();
      if (bus.load_o !== 3'b000) early++;
    end
    rstn = 1'b0;
    step();
    if (bus.load_o !== 3'b000) early++;
    rstn = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (n == 12) bus.key_a_n = 1'b1;
      if (bus.load_o !== 3'b000) begin
        pulses++;
        if (at < 0) at = n;
      end
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL reset_mid_early: %0d pulses around reset, required 0", early);
    end
    checks++;
    if (pulses != 1 || at != LAT) begin
      failures++;
      $display("FAIL reset_mid_pulse: count=%0d at=%0d, required 1 at %0d", pulses, at, LAT);
    end
    checks++;
    if (bus.A_o !== 16'h5A5A || bus.B_o !== 16'h0 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_value: A=%h B=%h valid=%b, required 5a5a/0000/0", bus.A_o, bus.B_o, bus.valid_o);
    end
  endtask

  task automatic test_c_load();
    int at = -1, pulses = 0;
    bus.data_i  = 16'h0007;
    bus.key_c_n = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (n == 10) bus.key_c_n = 1'b1;
      if (bus.load_o !== 3'b000) begin
        pulses++;
        if (at < 0 && bus.load_o === 3'b100) at = n;
      end
    end
    checks++;
    if (pulses != 1 || at != LAT || bus.C_o !== 4'h7 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL c_load: count=%0d at=%0d C=%h valid=%b, required 1 at %0d C=7 valid=0", pulses, at, bus.C_o, bus.valid_o, LAT);
    end
  endtask

  task automatic test_random();
    int rem[3] = '{0, 0, 0};
    logic [2:0] lvl = 3'b111;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (rem[i] == 0) begin
          lvl[i] = $urandom_range(0, 1) != 0;
          rem[i] = $urandom_range(1, 2 * D + 3);
        end
        rem[i]--;
      end
      {bus.key_c_n, bus.key_b_n, bus.key_a_n} = lvl;
      if ($urandom_range(0, 7) == 0) bus.data_i = 16'($urandom);
      rstn = ($urandom_range(0, 499) != 0);
      step();
      checks++;
      if (bus.load_o !== m_load || bus.update_o !== (|m_load)) begin
        failures++;
        $display("FAIL rand_pulse cycle %0d: load=%b update=%b, required %b/%b", n, bus.load_o, bus.update_o, m_load, |m_load);
      end
      checks++;
      if (bus.A_o !== m_a || bus.B_o !== m_b || bus.C_o !== m_c) begin
        failures++;
        $display("FAIL rand_operands cycle %0d: A=%h B=%h C=%h, required %h/%h/%h", n, bus.A_o, bus.B_o, bus.C_o, m_a, m_b, m_c);
      end
      checks++;
      if (bus.valid_o !== (&m_flags)) begin
        failures++;
        $display("FAIL rand_valid cycle %0d: valid=%b, required %b", n, bus.valid_o, &m_flags);
      end
    end
    rstn = 1'b1;
  endtask

  initial begin
    bus.data_i  = 16'h0;
    bus.key_a_n = 1'b1;
    bus.key_b_n = 1'b1;
    bus.key_c_n = 1'b1;
    test_reset();
    test_single_a();
    idle(20);
    test_bounce_b();
    idle(20);
    test_simult_ac();
    idle(20);
    test_reset_mid();
    idle(20);
    test_c_load();
    idle(20);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
